// File: rtl/cpu_defs_pkg.sv
// Shared core definitions: architectural constants and the IF/ID pipeline entry
// that the fetch stage produces and the decode stage consumes.
package cpu_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0] EXC_VECTOR = 32'h0000_0380;
  localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            adel;
  } if_id_t;

  function automatic logic misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_stage_npc_sel.sv
// Next-PC priority mux: exception flush, then a held redirect, then a live
// branch, then the sequential address.
module npc_sel
  import cpu_defs::*;
(
  input  logic            exc_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            pend_i,
  input  logic [XLEN-1:0] pend_pc_i,
  input  logic            br_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  output logic [XLEN-1:0] npc_o
);

  always_comb begin
    npc_o = pc_plus4_i;
    if (exc_i) begin
      npc_o = exc_pc_i;
    end else if (pend_i) begin
      npc_o = pend_pc_i;
    end else if (br_i) begin
      npc_o = br_pc_i;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, and hands the
// fetched word to decode through the IF/ID register with a valid/ready handshake.
module if_fetch_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = cpu_defs::EXC_VECTOR,
  parameter logic [31:0] NOP_INST   = cpu_defs::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_addr,
  input  logic [31:0] inst_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_flush,
  input  logic [31:0] exc_pc,
  input  logic        exc_use_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel
);

  logic [31:0] pc_q, pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  if_id_t      ifid_q, ifid_d;

  logic        advance;
  logic [31:0] exc_tgt;
  logic [31:0] npc;

  assign advance = !ifid_q.valid || id_ready;
  assign exc_tgt = exc_use_pc ? exc_pc : EXC_VECTOR;

  npc_sel u_npc_sel (
    .exc_i      (exc_flush),
    .exc_pc_i   (exc_tgt),
    .pend_i     (pend_vld_q),
    .pend_pc_i  (pend_pc_q),
    .br_i       (br_taken),
    .br_pc_i    (br_target),
    .pc_plus4_i (pc_q + 32'd4),
    .npc_o      (npc)
  );

  // The flush moves the PC even while decode is stalled; otherwise the PC only
  // moves when the IF/ID slot is being refilled.
  always_comb begin
    pc_d = pc_q;
    if (exc_flush || advance) begin
      pc_d = npc;
    end
  end

  // A branch seen while stalled is remembered so the delay slot is still
  // captured first; ID keeps presenting it, so later assertions are ignored.
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    if (exc_flush || advance) begin
      pend_vld_d = 1'b0;
    end else if (br_taken && !pend_vld_q) begin
      pend_vld_d = 1'b1;
      pend_pc_d  = br_target;
    end
  end

  always_comb begin
    ifid_d = ifid_q;
    if (exc_flush) begin
      ifid_d.valid = 1'b0;
    end else if (advance) begin
      ifid_d.valid = 1'b1;
      ifid_d.pc    = pc_q;
      ifid_d.adel  = misaligned(pc_q);
      ifid_d.inst  = misaligned(pc_q) ? NOP_INST : inst_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
      ifid_q     <= '{valid: 1'b0, pc: '0, inst: NOP_INST, adel: 1'b0};
    end else begin
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      ifid_q     <= ifid_d;
    end
  end

  assign inst_addr = pc_q;
  assign if_valid  = ifid_q.valid;
  assign if_pc     = ifid_q.pc;
  assign if_inst   = ifid_q.inst;
  assign if_adel   = ifid_q.adel;

endmodule
